// File: rtl/baser_rx_block_sync.sv
// baser_rx_block_sync
// 10GBASE-R receive block synchronizer with an optional descrambler.
//
// The block takes raw 66-bit blocks from the GTX gearbox. It acquires and
// holds 64b/66b block lock, requests bit slips from the transceiver while
// hunting for lock, and can optionally remove the x^58+x^39+1
// self-synchronizing scrambler.
//
// Build option: define BASER_RX_DESCRAMBLER_EN to build the descrambler.
// When it is not defined, decode_data_o is gt_data_i registered unmodified
// and no history register is built. Use that build for PRBS and near-end
// loopback bring-up.
//
// Lock FSM:
//   state      | meaning
//   LOCK_INIT  | entry after reset, lock cleared
//   RESET_CNT  | clear header and invalid-header counters
//   TEST_SH    | count headers of valid blocks, decide lock/slip
//   SLIP       | one-cycle bit-slip request to the GTX
//   SLIP_WAIT  | let the GTX settle after a slip; blocks are ignored
//
// All outputs are registered, with one cycle of latency from input to output.

module baser_rx_block_sync #(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVALID_MAX   = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] gt_data_i,
  input  logic [1:0]  gt_head_i,
  input  logic        gt_data_vld_i,
  output logic [63:0] decode_data_o,
  output logic [1:0]  decode_head_o,
  output logic        decode_data_vld_o,
  output logic        gt_slip_o,
  output logic        block_lock_o
);

  localparam logic [6:0] SH_CNT_LIM = 7'(SH_CNT_MAX);
  localparam logic [4:0] SH_INV_LIM = 5'(SH_INVALID_MAX);
  localparam int         WAIT_W     = $clog2(SLIP_WAIT_CYCLES + 1);
  // The wait counter counts down to zero, so a load value of N-1 gives
  // exactly N cycles in SLIP_WAIT.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    LOCK_INIT = 3'd0,
    RESET_CNT = 3'd1,
    TEST_SH   = 3'd2,
    SLIP      = 3'd3,
    SLIP_WAIT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        sh_cnt_q, sh_cnt_d;
  logic [4:0]        sh_inv_q, sh_inv_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;

  logic [63:0]       dout_q, dout_d;
  logic [1:0]        head_q, head_d;
  logic              dvld_q, dvld_d;

  logic              sh_valid;
  logic [6:0]        sh_cnt_inc;
  logic [4:0]        sh_inv_inc;
  logic [63:0]       descr;

  assign sh_valid   = gt_head_i[0] ^ gt_head_i[1];
  assign sh_cnt_inc = sh_cnt_q + 7'd1;
  assign sh_inv_inc = sh_inv_q + {4'd0, ~sh_valid};

  // Lock FSM next state, counters and slip request.
  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    sh_inv_d = sh_inv_q;
    wait_d   = wait_q;
    lock_d   = lock_q;
    slip_d   = 1'b0;

    case (state_q)
      LOCK_INIT: begin
        lock_d  = 1'b0;
        state_d = RESET_CNT;
      end

      RESET_CNT: begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
        state_d  = TEST_SH;
      end

      TEST_SH: begin
        if (gt_data_vld_i) begin
          sh_cnt_d = sh_cnt_inc;
          sh_inv_d = sh_inv_inc;
          // The invalid-header checks come first. When the window completes
          // on the same block as a lock-dropping invalid header, the slip wins.
          if (!lock_q && (sh_inv_inc != 5'd0)) begin
            state_d = SLIP;
          end else if (lock_q && (sh_inv_inc == SH_INV_LIM)) begin
            lock_d  = 1'b0;
            state_d = SLIP;
          end else if (sh_cnt_inc == SH_CNT_LIM) begin
            if (sh_inv_inc == 5'd0) begin
              lock_d = 1'b1;
            end
            state_d = RESET_CNT;
          end
        end
      end

      SLIP: begin
        wait_d  = WAIT_LOAD;
        state_d = SLIP_WAIT;
      end

      SLIP_WAIT: begin
        if (wait_q == '0) begin
          state_d = RESET_CNT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      default: begin
        lock_d  = 1'b0;
        state_d = LOCK_INIT;
      end
    endcase

    // The slip output is registered. It is raised on the edge that enters
    // SLIP, so the pulse lines up with the fall of block lock.
    slip_d = (state_d == SLIP);
  end

  // Lock FSM state and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LOCK_INIT;
      sh_cnt_q <= '0;
      sh_inv_q <= '0;
      wait_q   <= '0;
      lock_q   <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      sh_inv_q <= sh_inv_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
      slip_q   <= slip_d;
    end
  end

`ifdef BASER_RX_DESCRAMBLER_EN
  // The history holds the last 58 scrambled bits of the previous valid block.
  // It is updated whether or not the block is locked, so the descrambler is
  // already synchronized by the time lock is declared.
  logic [57:0]  hist_q, hist_d;
  logic [121:0] scr_stream;

  assign scr_stream = {gt_data_i, hist_q};

  // Descramble: out[i] = in[i] ^ s[i-39] ^ s[i-58]. In scr_stream, current
  // bit i sits at index i+58.
  always_comb begin
    descr  = '0;
    hist_d = hist_q;
    for (int i = 0; i < 64; i++) begin
      descr[i] = gt_data_i[i] ^ scr_stream[i + 19] ^ scr_stream[i];
    end
    if (gt_data_vld_i) begin
      hist_d = gt_data_i[63:6];
    end
  end

  // Descrambler history register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  // Bring-up build: the payload passes through unscrambled.
  always_comb begin
    descr = gt_data_i;
  end
`endif

  // Output data path next state. Data and header hold on pause cycles.
  always_comb begin
    dout_d = dout_q;
    head_d = head_q;
    dvld_d = gt_data_vld_i & lock_d;
    if (gt_data_vld_i) begin
      dout_d = descr;
      head_d = gt_head_i;
    end
  end

  // Output data path registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
      head_q <= '0;
      dvld_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      head_q <= head_d;
      dvld_q <= dvld_d;
    end
  end

  assign decode_data_o     = dout_q;
  assign decode_head_o     = head_q;
  assign decode_data_vld_o = dvld_q;
  assign gt_slip_o         = slip_q;
  assign block_lock_o      = lock_q;

endmodule
